// File: rtl/shift8_tx.sv
// MSB-first serializer with SPI mode 0 style sck and full-duplex capture.
// Bits go out on sdo while sdi is shifted into the LSB of the same register.
module shift8_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             sdi,
    output logic             sdo,
    output logic             sck,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic             smp_q, smp_d;
    logic             sdo_q, sdo_d;
    logic             sck_q, sck_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] sr_shift;

    assign sr_shift = {sr_q[WIDTH-2:0], smp_q};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        smp_d   = smp_q;
        sdo_d   = sdo_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_SHIFT;
                    sr_d    = in;
                    cnt_d   = '0;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    sdo_d   = in[WIDTH-1];
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        smp_d = sdi;
                    end else begin
                        // falling edge: shift in the sample, present the next MSB
                        sr_d  = sr_shift;
                        sdo_d = sr_q[WIDTH-2];
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            out_d   = sr_shift;
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            sdo_d   = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            smp_q   <= 1'b0;
            sdo_q   <= 1'b0;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            sdo_q   <= sdo_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign sdo  = sdo_q;
    assign sck  = sck_q;
    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_shift8_tx.sv
// Bench for shift8_tx: scoreboarded transfers at DIV=1,2,3,
// load-while-busy, back-to-back loads and mid-transfer reset.
module tb_shift8_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       load;
    logic       sdi_drv;
    logic       loop_en;
    logic [1:0] sel;

    logic       sdo1, sck1, busy1, done1;
    logic       sdo2, sck2, busy2, done2;
    logic       sdo3, sck3, busy3, done3;
    logic [7:0] out1, out2, out3;

    logic       m_sdo, m_sck, m_busy, m_done;
    logic [7:0] m_out;

    int         n_chk;
    int         n_fail;
    logic [7:0] sb[$];

    shift8_tx #(.WIDTH(8), .DIV(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in(din),
        .load(load && (sel == 2'd1)),
        .sdi(loop_en ? sdo1 : sdi_drv),
        .sdo(sdo1), .sck(sck1), .busy(busy1),
        .done(done1), .out(out1)
    );

    shift8_tx #(.WIDTH(8), .DIV(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in(din),
        .load(load && (sel == 2'd2)),
        .sdi(loop_en ? sdo2 : sdi_drv),
        .sdo(sdo2), .sck(sck2), .busy(busy2),
        .done(done2), .out(out2)
    );

    shift8_tx #(.WIDTH(8), .DIV(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in(din),
        .load(load && (sel == 2'd3)),
        .sdi(loop_en ? sdo3 : sdi_drv),
        .sdo(sdo3), .sck(sck3), .busy(busy3),
        .done(done3), .out(out3)
    );

    assign m_sdo  = (sel == 2'd1) ? sdo1  : (sel == 2'd3) ? sdo3  : sdo2;
    assign m_sck  = (sel == 2'd1) ? sck1  : (sel == 2'd3) ? sck3  : sck2;
    assign m_busy = (sel == 2'd1) ? busy1 : (sel == 2'd3) ? busy3 : busy2;
    assign m_done = (sel == 2'd1) ? done1 : (sel == 2'd3) ? done3 : done2;
    assign m_out  = (sel == 2'd1) ? out1  : (sel == 2'd3) ? out3  : out2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every done pulse pops one expected received byte
    always @(negedge clk) begin
        if (rst_n && m_done) begin
            if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else check("sb_out", {24'd0, m_out}, {24'd0, sb.pop_front()});
        end
    end

    task automatic xfer(input logic [7:0] d, input logic [7:0] pat,
                        input bit lb, input bit mid, input int dv,
                        output logic [7:0] seq);
        int   cyc;
        int   nr;
        int   len;
        int   mn;
        int   mx;
        logic prev;
        @(negedge clk);
        din     = d;
        loop_en = lb;
        sdi_drv = pat[7];
        load    = 1'b1;
        sb.push_back(lb ? d : pat);
        @(negedge clk);
        load = 1'b0;
        check("busy_start", {31'd0, m_busy}, 32'd1);
        check("sdo_first", {31'd0, m_sdo}, {31'd0, d[7]});
        cyc  = 1;
        nr   = 0;
        len  = 1;
        mn   = 1000;
        mx   = 0;
        prev = m_sck;
        seq  = '0;
        while (cyc < 400) begin
            @(negedge clk);
            if (m_sck != prev) begin
                if (len < mn) mn = len;
                if (len > mx) mx = len;
                len = 1;
                if (m_sck && nr < 8) begin
                    seq[7-nr] = m_sdo;
                    nr++;
                    if (nr < 8) sdi_drv = pat[7-nr];
                end
            end else begin
                len++;
            end
            prev = m_sck;
            if (!m_busy) break;
            cyc++;
            if (mid && cyc == 5) begin
                load = 1'b1;
                din  = 8'hFF;
            end
            if (mid && cyc == 6) begin
                load = 1'b0;
                din  = d;
            end
        end
        check("busy_len", cyc, 2 * dv * 8);
        check("half_min", mn, dv);
        check("half_max", mx, dv);
        check("done_pulse", {31'd0, m_done}, 32'd1);
        check("end_idle", {30'd0, m_sck, m_sdo}, 32'd0);
        @(negedge clk);
        check("done_once", {31'd0, m_done}, 32'd0);
    endtask

    initial begin
        logic [7:0] seq;
        int         cyc;
        int         wins;
        int         len;
        int         gap;
        int         wl[3];
        int         gl[2];
        int         nr;
        logic       pb;
        bit         seen;
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        din     = 8'h00;
        sdi_drv = 1'b0;
        loop_en = 1'b1;
        sel     = 2'd2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle", {20'd0, m_sck, m_sdo, m_busy, m_done, m_out}, 32'd0);
        end

        xfer(8'hA6, 8'h00, 1'b1, 1'b0, 2, seq);
        check("lb_seq", {24'd0, seq}, 32'hA6);

        xfer(8'h00, 8'b1100_1011, 1'b0, 1'b0, 2, seq);
        check("zero_sdo", {24'd0, seq}, 32'h00);

        xfer(8'h3C, 8'h00, 1'b1, 1'b1, 2, seq);
        check("mid_seq", {24'd0, seq}, 32'h3C);

        @(negedge clk);
        din     = 8'h81;
        loop_en = 1'b1;
        load    = 1'b1;
        wins    = 0;
        len     = 0;
        gap     = 0;
        cyc     = 0;
        wl      = '{0, 0, 0};
        gl      = '{0, 0};
        pb      = m_busy;
        while (cyc < 1000 && !(wins == 3 && !m_busy)) begin
            @(negedge clk);
            cyc++;
            if (m_busy && !pb && wins < 3) begin
                wins++;
                sb.push_back(8'h81);
                if (wins > 1) gl[wins-2] = gap;
                len = 0;
                if (wins == 3) load = 1'b0;
            end
            if (m_busy) begin
                len++;
            end else begin
                if (pb && wins > 0) begin
                    wl[wins-1] = len;
                    gap = 0;
                end
                gap++;
            end
            pb = m_busy;
        end
        load = 1'b0;
        check("b2b_bound", {31'd0, cyc < 1000}, 32'd1);
        check("b2b_win0", wl[0], 32);
        check("b2b_win1", wl[1], 32);
        check("b2b_win2", wl[2], 32);
        check("b2b_gap0", gl[0], 1);
        check("b2b_gap1", gl[1], 1);
        repeat (3) @(negedge clk);

        din  = 8'hE7;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nr   = 0;
        cyc  = 0;
        pb   = m_sck;
        while (nr < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_sck && !pb) nr++;
            pb = m_sck;
        end
        check("rst_reach", nr, 3);
        #2 rst_n = 1'b0;
        #1 check("rst_async",
                 {20'd0, m_sck, m_sdo, m_busy, m_done, m_out}, 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_done || m_busy) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (m_done || m_busy) seen = 1'b1;
        end
        check("rst_quiet", {31'd0, seen}, 32'd0);

        xfer(8'h5A, 8'h00, 1'b1, 1'b0, 2, seq);
        check("post_rst_seq", {24'd0, seq}, 32'h5A);

        sel = 2'd1;
        xfer(8'hC3, 8'h00, 1'b1, 1'b0, 1, seq);
        check("div1_seq", {24'd0, seq}, 32'hC3);

        sel = 2'd3;
        xfer(8'h96, 8'h2D, 1'b0, 1'b0, 3, seq);
        check("div3_seq", {24'd0, seq}, 32'h96);

        repeat (3) @(negedge clk);
        check("sb_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
